// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer blocks (read and write side).
// Width-generic Gray helpers operate on a 32-bit carrier masked to the requested width.
package fifo_pkg;

    localparam logic [31:0] PTR_RST    = '0;
    localparam logic        EMPTY_RST  = 1'b1;
    localparam logic        AEMPTY_RST = 1'b1;

    function automatic int unsigned depth_of(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    function automatic logic [31:0] width_mask(input int unsigned w);
        return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
        logic [31:0] bm;
        bm = b & width_mask(w);
        return (bm >> 1) ^ bm;
    endfunction

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
        logic [31:0] gm;
        logic [31:0] b;
        gm = g & width_mask(w);
        b  = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; prefix XOR from the MSB down.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/rptr_empty_level.sv
// Read-domain pointer and status logic of the dual-clock FIFO: binary/Gray read
// pointer, registered empty, almost-empty, fill level and sticky underflow.
module rptr_empty_level
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                rerr_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = int'(depth_of(ADDRSIZE));
    // Out-of-range thresholds are clamped so the flag still means "nearly drained".
    localparam int AE_TH_INT = (AEMPTY_THRESH >= DEPTH) ? DEPTH - 1 :
                               (AEMPTY_THRESH < 0)      ? 0         : AEMPTY_THRESH;
    localparam logic [PW-1:0] AE_TH = PW'(AE_TH_INT);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] lvl_next;
    logic          rd_ok;
    logic          rempty_val;
    logic          raempty_val;

    gray2bin #(.W(PW)) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    // Modular arithmetic on PW bits keeps compare and subtraction valid across wrap.
    always_comb begin
        rd_ok       = rinc & ~rempty;
        rbinnext    = rbin + PW'(rd_ok);
        rgraynext   = PW'(bin2gray(32'(rbinnext), PW));
        lvl_next    = wbin_s - rbinnext;
        rempty_val  = (rgraynext == rq2_wptr);
        raempty_val = (lvl_next <= AE_TH);
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= PW'(PTR_RST);
            rptr    <= PW'(PTR_RST);
            rempty  <= EMPTY_RST;
            raempty <= AEMPTY_RST;
            rlevel  <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= rempty_val;
            raempty <= raempty_val;
            rlevel  <= lvl_next;
        end
    end

    // A read against an empty FIFO outranks a same-cycle clear so no error is lost.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow <= 1'b0;
        end else if (rinc && rempty) begin
            runderflow <= 1'b1;
        end else if (rerr_clr) begin
            runderflow <= 1'b0;
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_level.sv
// Self-checking bench for rptr_empty_level: directed vector table plus sequences
// for full level, wrap-around with a count-based model, and mid-stream reset.
module tb_rptr_empty_level;
    import fifo_pkg::*;

    localparam int AS = 4;
    localparam int PW = AS + 1;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rinc;
    logic [PW-1:0] rq2_wptr;
    logic          rerr_clr;
    logic [AS-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          rempty;
    logic          raempty;
    logic [PW-1:0] rlevel;
    logic          runderflow;

    rptr_empty_level #(.ADDRSIZE(AS), .AEMPTY_THRESH(2)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .rerr_clr   (rerr_clr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [PW-1:0] gray_of(input int b);
        logic [31:0] g;
        g = bin2gray(32'(b % 32), PW);
        return PW'(g);
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rerr_clr = 1'b0;
        rq2_wptr = '0;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    typedef struct {
        logic rinc;
        logic clr;
        int   wbin;
        int   raddr;
        int   rptr;
        logic rempty;
        logic raempty;
        int   rlevel;
        logic unf;
    } vec_t;

    vec_t vecs[15];

    int   wcnt, rcnt, m_lvl, toggles;
    logic do_rd, acc;
    logic [PW-1:0] prev_rptr;

    initial begin
        //            rinc  clr   w  raddr rptr empty aempty lvl unf
        vecs[0]  = '{1'b0, 1'b0, 5, 0, 0,  1'b0, 1'b0, 5, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 5, 1, 1,  1'b0, 1'b0, 4, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5, 2, 3,  1'b0, 1'b0, 3, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5, 3, 2,  1'b0, 1'b1, 2, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 5, 4, 6,  1'b0, 1'b1, 1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5, 5, 7,  1'b1, 1'b1, 0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 5, 5, 7,  1'b1, 1'b1, 0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 5, 5, 7,  1'b1, 1'b1, 0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 5, 5, 7,  1'b1, 1'b1, 0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 5, 5, 7,  1'b1, 1'b1, 0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 9, 5, 7,  1'b0, 1'b0, 4, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 9, 6, 5,  1'b0, 1'b0, 3, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 9, 7, 4,  1'b0, 1'b1, 2, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 9, 8, 12, 1'b0, 1'b1, 1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 9, 9, 13, 1'b1, 1'b1, 0, 1'b0};

        // Reset state
        do_reset();
        check("rst_rempty",     32'(rempty),     32'd1);
        check("rst_raempty",    32'(raempty),    32'd1);
        check("rst_rptr",       32'(rptr),       32'd0);
        check("rst_raddr",      32'(raddr),      32'd0);
        check("rst_rlevel",     32'(rlevel),     32'd0);
        check("rst_runderflow", 32'(runderflow), 32'd0);

        // Fill/drain, underflow and clear priority
        for (int i = 0; i < 15; i++) begin
            rinc     = vecs[i].rinc;
            rerr_clr = vecs[i].clr;
            rq2_wptr = gray_of(vecs[i].wbin);
            tick();
            check($sformatf("v%0d_raddr", i),   32'(raddr),      32'(vecs[i].raddr));
            check($sformatf("v%0d_rptr", i),    32'(rptr),       32'(vecs[i].rptr));
            check($sformatf("v%0d_rempty", i),  32'(rempty),     32'(vecs[i].rempty));
            check($sformatf("v%0d_raempty", i), 32'(raempty),    32'(vecs[i].raempty));
            check($sformatf("v%0d_rlevel", i),  32'(rlevel),     32'(vecs[i].rlevel));
            check($sformatf("v%0d_unf", i),     32'(runderflow), 32'(vecs[i].unf));
        end
        rinc     = 1'b0;
        rerr_clr = 1'b0;

        // Full level: write pointer a whole depth ahead
        do_reset();
        rq2_wptr = gray_of(16);
        tick();
        check("full_rlevel",  32'(rlevel),  32'd16);
        check("full_rempty",  32'(rempty),  32'd0);
        check("full_raempty", 32'(raempty), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            rinc = 1'b1;
            tick();
            check($sformatf("drain%0d_rlevel", k), 32'(rlevel), 32'(16 - k));
        end
        rinc = 1'b0;
        check("drained_rempty",  32'(rempty),  32'd1);
        check("drained_raempty", 32'(raempty), 32'd1);
        check("drained_rptr",    32'(rptr),    32'd24);

        // Wrap-around and Gray property against an occupancy-count model
        do_reset();
        wcnt = 0; rcnt = 0; m_lvl = 0; toggles = 0;
        prev_rptr = rptr;
        for (int cyc = 0; cyc < 2000 && rcnt < 40; cyc++) begin
            do_rd = 1'($urandom_range(0, 1));
            if (wcnt < 40 && (wcnt - rcnt) < 16 && $urandom_range(0, 2) != 0) wcnt++;
            rinc     = do_rd;
            rq2_wptr = gray_of(wcnt);
            acc = do_rd && (m_lvl != 0);
            if (acc) rcnt++;
            m_lvl = wcnt - rcnt;
            tick();
            check("wrap_rlevel",  32'(rlevel),  32'(m_lvl));
            check("wrap_rempty",  32'(rempty),  32'(m_lvl == 0));
            check("wrap_raempty", 32'(raempty), 32'(m_lvl <= 2));
            check("wrap_rptr",    32'(rptr),    32'(gray_of(rcnt)));
            check("wrap_raddr",   32'(raddr),   32'(rcnt % 16));
            check("wrap_empty_cmp", 32'(rempty), 32'(rptr == rq2_wptr));
            check("wrap_level_bound", 32'(rlevel <= 5'd16), 32'd1);
            check("wrap_gray_step", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
            if (rptr[PW-1] != prev_rptr[PW-1]) toggles++;
            prev_rptr = rptr;
        end
        rinc = 1'b0;
        check("wrap_reads",       32'(rcnt),    32'd40);
        check("wrap_msb_toggles", 32'(toggles), 32'd2);
        check("wrap_final_rptr",  32'(rptr),    32'd12);

        // Mid-stream asynchronous reset with rbin=7, underflow set, FIFO non-empty
        do_reset();
        rq2_wptr = gray_of(7);
        tick();
        rinc = 1'b1;
        repeat (8) tick();
        rinc = 1'b0;
        rq2_wptr = gray_of(10);
        tick();
        check("pre_rst_raddr", 32'(raddr),      32'd7);
        check("pre_rst_unf",   32'(runderflow), 32'd1);
        check("pre_rst_level", 32'(rlevel),     32'd3);
        #2;
        rrst_n = 1'b0;
        #1;
        check("mid_rst_rempty",     32'(rempty),     32'd1);
        check("mid_rst_raempty",    32'(raempty),    32'd1);
        check("mid_rst_rptr",       32'(rptr),       32'd0);
        check("mid_rst_raddr",      32'(raddr),      32'd0);
        check("mid_rst_rlevel",     32'(rlevel),     32'd0);
        check("mid_rst_runderflow", 32'(runderflow), 32'd0);
        @(negedge rclk);
        rrst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
